// File: rtl/game_state_ctrl.sv
// Game-flow controller for the brick-breaker core: level progression, pause,
// timed level-clear interlude, start/restart handshake and live brick count.
module game_state_ctrl #(
  parameter int N_BRICKS   = 50,
  parameter int HEALTH_W   = 4,
  parameter int N_LEVELS   = 3,
  parameter int CLEAR_HOLD = 100,
  parameter int LOAD_GUARD = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          pause,
  input  logic [HEALTH_W-1:0]                           health,
  input  logic [N_BRICKS-1:0]                           bk_touched,
  output logic [1:0]                                    game_state,
  output logic                                          paused,
  output logic [((N_LEVELS > 1) ? $clog2(N_LEVELS) : 1)-1:0] level,
  output logic                                          level_load,
  output logic [$clog2(N_BRICKS+1)-1:0]                 bricks_left,
  output logic                                          clear_busy
);

  localparam int LVL_W = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
  localparam int BL_W  = $clog2(N_BRICKS + 1);
  localparam int GRD_W = $clog2(LOAD_GUARD + 1);
  localparam int CLR_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(N_LEVELS - 1);

  typedef enum logic [2:0] {IDLE, PLAY, PAUSE, CLEAR, WIN, LOSE} state_t;

  state_t            state, state_n;
  logic [GRD_W-1:0]  guard, guard_n;
  logic [CLR_W-1:0]  clr_cnt, clr_n;
  logic [LVL_W-1:0]  level_n;
  logic              load_n;
  logic              prev_start, prev_pause;
  logic              start_rise, pause_rise, all_done;
  logic [BL_W-1:0]   zero_cnt;

  assign start_rise = start & ~prev_start;
  assign pause_rise = pause & ~prev_pause;
  assign all_done   = &bk_touched;

  function automatic logic [1:0] gs_of(state_t s);
    case (s)
      PLAY, PAUSE, CLEAR: gs_of = 2'b01;
      WIN:                gs_of = 2'b11;
      LOSE:               gs_of = 2'b10;
      default:            gs_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < N_BRICKS; i++) begin
      if (!bk_touched[i]) zero_cnt = zero_cnt + BL_W'(1);
    end
  end

  // Brick completion outranks death, which outranks pause, while playing.
  always_comb begin
    state_n = state;
    guard_n = guard;
    clr_n   = clr_cnt;
    level_n = level;
    load_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = PLAY;
          level_n = '0;
          load_n  = 1'b1;
          guard_n = GRD_W'(LOAD_GUARD);
        end
      end
      PLAY: begin
        if (guard != '0) guard_n = guard - GRD_W'(1);
        if (all_done && guard == '0) begin
          if (level == LAST_LEVEL) begin
            state_n = WIN;
          end else begin
            state_n = CLEAR;
            clr_n   = CLR_W'(CLEAR_HOLD - 1);
          end
        end else if (health == '0) begin
          state_n = LOSE;
        end else if (pause_rise) begin
          state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_rise) state_n = PLAY;
      end
      CLEAR: begin
        if (clr_cnt == '0) begin
          state_n = PLAY;
          level_n = level + LVL_W'(1);
          load_n  = 1'b1;
          guard_n = GRD_W'(LOAD_GUARD);
        end else begin
          clr_n = clr_cnt - CLR_W'(1);
        end
      end
      WIN, LOSE: begin
        if (start_rise) begin
          state_n = IDLE;
          level_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      guard       <= '0;
      clr_cnt     <= '0;
      level       <= '0;
      level_load  <= 1'b0;
      game_state  <= 2'b00;
      paused      <= 1'b0;
      clear_busy  <= 1'b0;
      bricks_left <= BL_W'(N_BRICKS);
      prev_start  <= 1'b1;
      prev_pause  <= 1'b1;
    end else begin
      state       <= state_n;
      guard       <= guard_n;
      clr_cnt     <= clr_n;
      level       <= level_n;
      level_load  <= load_n;
      game_state  <= gs_of(state_n);
      paused      <= (state_n == PAUSE);
      clear_busy  <= (state_n == CLEAR);
      bricks_left <= zero_cnt;
      prev_start  <= start;
      prev_pause  <= pause;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scenario bench for game_state_ctrl: stimulus tables with hand-derived
// expected outputs, queued as each cycle is driven and compared after the edge.
module tb_game_state_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic [3:0] health;
  logic [7:0] bk_touched;
  logic [1:0] game_state;
  logic       paused;
  logic [0:0] level;
  logic       level_load;
  logic [3:0] bricks_left;
  logic       clear_busy;

  game_state_ctrl #(
    .N_BRICKS(8), .HEALTH_W(4), .N_LEVELS(2), .CLEAR_HOLD(4), .LOAD_GUARD(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .health(health), .bk_touched(bk_touched), .game_state(game_state),
    .paused(paused), .level(level), .level_load(level_load),
    .bricks_left(bricks_left), .clear_busy(clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, pa;
    logic [3:0] hl;
    logic [7:0] bk;
    logic [9:0] exp;
    string      nm;
  } step_t;

  step_t stim[$];
  step_t sb[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Expected bricks_left is the zero count of the bk value driven before the edge.
  task automatic add(input logic r, input logic s, input logic p,
                     input logic [3:0] h, input logic [7:0] b,
                     input logic [1:0] g, input logic pp, input logic lv,
                     input logic ld, input logic cb, input string nm);
    step_t      t;
    logic [7:0] inv;
    logic [3:0] bl;
    inv  = ~b;
    bl   = r ? 4'd8 : 4'($countones(inv));
    t.rst = r; t.st = s; t.pa = p; t.hl = h; t.bk = b;
    t.exp = {g, pp, lv, ld, cb, bl};
    t.nm  = nm;
    stim.push_back(t);
  endtask

  task automatic test_reset();
    step_t s, e;
    logic [9:0] obs;
    add(1, 1, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "rst_held");
    add(0, 1, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "start_held_idle");
    add(0, 1, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "start_held_idle2");
    add(0, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "start_release");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 1, 0, "start_press");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 0, 0, "load_one_cycle");
    while (stim.size() != 0) begin
      s = stim.pop_front();
      reset = s.rst; start = s.st; pause = s.pa; health = s.hl; bk_touched = s.bk;
      sb.push_back(s);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {game_state, paused, level, level_load, clear_busy, bricks_left};
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got {gs,p,lv,ld,cb,bl}=%b want %b", e.nm, obs, e.exp);
      end
    end
  endtask

  task automatic test_level_clear();
    step_t s, e;
    logic [9:0] obs;
    add(1, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "lc_reset");
    add(0, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "lc_idle");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 1, 0, "lc_start");
    add(0, 0, 0, 3, 8'h00, 2'b01, 0, 0, 0, 0, "lc_guard1");
    add(0, 0, 0, 3, 8'h00, 2'b01, 0, 0, 0, 0, "lc_guard0");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "lc_enter_clear");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "lc_clear2");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "lc_clear3");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "lc_clear4");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 1, 1, 0, "lc_next_level");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 1, 0, 0, "lc_guard_hold1");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 1, 0, 0, "lc_guard_hold2");
    add(0, 0, 0, 3, 8'h00, 2'b01, 0, 1, 0, 0, "lc_bricks_reload");
    while (stim.size() != 0) begin
      s = stim.pop_front();
      reset = s.rst; start = s.st; pause = s.pa; health = s.hl; bk_touched = s.bk;
      sb.push_back(s);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {game_state, paused, level, level_load, clear_busy, bricks_left};
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got {gs,p,lv,ld,cb,bl}=%b want %b", e.nm, obs, e.exp);
      end
    end
  endtask

  // Continues from the level-1 PLAY state left by test_level_clear.
  task automatic test_win();
    step_t s, e;
    logic [9:0] obs;
    add(0, 0, 0, 0, 8'hFF, 2'b11, 0, 1, 0, 0, "win_beats_death");
    add(0, 0, 1, 0, 8'hFF, 2'b11, 0, 1, 0, 0, "win_ignores_pause");
    add(0, 1, 0, 0, 8'hFF, 2'b00, 0, 0, 0, 0, "win_to_idle");
    add(0, 1, 0, 3, 8'hFF, 2'b00, 0, 0, 0, 0, "idle_needs_new_press");
    add(0, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "idle_after_win");
    while (stim.size() != 0) begin
      s = stim.pop_front();
      reset = s.rst; start = s.st; pause = s.pa; health = s.hl; bk_touched = s.bk;
      sb.push_back(s);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {game_state, paused, level, level_load, clear_busy, bricks_left};
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got {gs,p,lv,ld,cb,bl}=%b want %b", e.nm, obs, e.exp);
      end
    end
  endtask

  task automatic test_lose_pause();
    step_t s, e;
    logic [9:0] obs;
    add(1, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "lp_reset");
    add(0, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "lp_idle");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 1, 0, "lp_start");
    add(0, 0, 0, 0, 8'h00, 2'b10, 0, 0, 0, 0, "lose_health0");
    add(0, 1, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "lose_to_idle");
    add(0, 0, 1, 3, 8'h00, 2'b00, 0, 0, 0, 0, "idle_ignores_pause");
    add(0, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "lp_idle2");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 1, 0, "lp_restart");
    add(0, 0, 1, 3, 8'h00, 2'b01, 1, 0, 0, 0, "pause_enter");
    add(0, 1, 0, 0, 8'h00, 2'b01, 1, 0, 0, 0, "pause_ignores_death");
    add(0, 0, 0, 0, 8'h00, 2'b01, 1, 0, 0, 0, "pause_hold");
    add(0, 0, 1, 0, 8'h00, 2'b01, 0, 0, 0, 0, "pause_resume");
    add(0, 0, 0, 0, 8'h00, 2'b10, 0, 0, 0, 0, "lose_after_resume");
    while (stim.size() != 0) begin
      s = stim.pop_front();
      reset = s.rst; start = s.st; pause = s.pa; health = s.hl; bk_touched = s.bk;
      sb.push_back(s);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {game_state, paused, level, level_load, clear_busy, bricks_left};
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got {gs,p,lv,ld,cb,bl}=%b want %b", e.nm, obs, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    step_t s, e;
    logic [9:0] obs;
    add(1, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "rmc_reset");
    add(0, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "rmc_idle");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 1, 0, "rmc_start");
    add(0, 0, 0, 3, 8'h00, 2'b01, 0, 0, 0, 0, "rmc_guard1");
    add(0, 0, 0, 3, 8'h00, 2'b01, 0, 0, 0, 0, "rmc_guard0");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "rmc_clear1");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "rmc_clear2");
    add(1, 0, 0, 3, 8'hFF, 2'b00, 0, 0, 0, 0, "rmc_reset_in_clear");
    add(0, 0, 0, 3, 8'hFF, 2'b00, 0, 0, 0, 0, "rmc_idle_after");
    while (stim.size() != 0) begin
      s = stim.pop_front();
      reset = s.rst; start = s.st; pause = s.pa; health = s.hl; bk_touched = s.bk;
      sb.push_back(s);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {game_state, paused, level, level_load, clear_busy, bricks_left};
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got {gs,p,lv,ld,cb,bl}=%b want %b", e.nm, obs, e.exp);
      end
    end
  endtask

  // Full back-to-back run to WIN, sampling the brick counter in IDLE, PAUSE and WIN.
  task automatic test_bricks_left();
    step_t s, e;
    logic [9:0] obs;
    add(1, 0, 0, 3, 8'h00, 2'b00, 0, 0, 0, 0, "bl_reset");
    add(0, 0, 0, 3, 8'h16, 2'b00, 0, 0, 0, 0, "bl_idle");
    add(0, 1, 0, 3, 8'h00, 2'b01, 0, 0, 1, 0, "bl_start");
    add(0, 0, 1, 3, 8'h00, 2'b01, 1, 0, 0, 0, "bl_pause_enter");
    add(0, 0, 0, 3, 8'h16, 2'b01, 1, 0, 0, 0, "bl_pause");
    add(0, 0, 1, 3, 8'h00, 2'b01, 0, 0, 0, 0, "bl_resume");
    add(0, 0, 0, 3, 8'h00, 2'b01, 0, 0, 0, 0, "bl_guard_retained");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "bl_clear1");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "bl_clear2");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "bl_clear3");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 0, 0, 1, "bl_clear4");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 1, 1, 0, "bl_level1");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 1, 0, 0, "bl_guard1");
    add(0, 0, 0, 3, 8'hFF, 2'b01, 0, 1, 0, 0, "bl_guard0");
    add(0, 0, 0, 3, 8'hFF, 2'b11, 0, 1, 0, 0, "bl_win_enter");
    add(0, 0, 0, 3, 8'h16, 2'b11, 0, 1, 0, 0, "bl_win");
    while (stim.size() != 0) begin
      s = stim.pop_front();
      reset = s.rst; start = s.st; pause = s.pa; health = s.hl; bk_touched = s.bk;
      sb.push_back(s);
      @(posedge clk); #1;
      e   = sb.pop_front();
      obs = {game_state, paused, level, level_load, clear_busy, bricks_left};
      n_cmp++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got {gs,p,lv,ld,cb,bl}=%b want %b", e.nm, obs, e.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; pause = 1'b0; health = 4'd3; bk_touched = 8'h00;
    $display("[TB] starting game_state_ctrl bench");
    test_reset();
    test_level_clear();
    test_win();
    test_lose_pause();
    test_reset_mid_clear();
    test_bricks_left();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
